green_centroid_tracker: RTL

Consumes the demosaiced RGB pixel stream in the VGA clock domain, alongside the VGA controller that paces it. Classifies each active pixel as "green marker" or not, accumulates the coordinate sums and the count of marker pixels per frame, and computes the marker centroid with a sequential divider during vertical blanking. Publishes a per-frame cursor position (oX, oY) with a one-cycle valid strobe for the downstream mouse/pointer logic.

---
 rtl/green_centroid_tracker_if.sv | 24 ++
 rtl/green_centroid_tracker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/green_centroid_tracker_if.sv
// Pixel stream in, per-frame centroid report out, between the VGA pixel path
// and the green-marker centroid tracker.
interface green_centroid_tracker_if;
  logic        iDE;
  logic        iVS;
  logic [7:0]  iRed;
  logic [7:0]  iGreen;
  logic [7:0]  iBlue;
  logic [9:0]  oX;
  logic [8:0]  oY;
  logic [18:0] oCount;
  logic        oFound;
  logic        oValid;

  modport master (
    output iDE, iVS, iRed, iGreen, iBlue,
    input  oX, oY, oCount, oFound, oValid
  );

  modport slave (
    input  iDE, iVS, iRed, iGreen, iBlue,
    output oX, oY, oCount, oFound, oValid
  );
endinterface

// File: rtl/green_centroid_tracker.sv
// Classifies green marker pixels, accumulates coordinate sums per frame and
// divides them during vertical blanking to publish a cursor position.
module green_centroid_tracker #(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter logic [7:0]  G_MIN     = 8'd128,
  parameter logic [7:0]  G_MARGIN  = 8'd32,
  parameter int          MIN_COUNT = 64
) (
  input  logic                      iCLK,
  input  logic                      iRST_N,
  green_centroid_tracker_if.slave   bus
);

  typedef enum logic [1:0] {ACCUM, DIV_X, DIV_Y, PUBLISH} state_t;

  state_t      state;
  logic [9:0]  x_cnt;
  logic [8:0]  y_cnt;
  logic        vs_d1, vs_d2;
  logic        mark_q;
  logic [9:0]  x_q;
  logic [8:0]  y_q;
  logic [27:0] sum_x, sum_y;
  logic [18:0] cnt;
  logic [27:0] quo, op_y;
  logic [18:0] rem, op_cnt;
  logic [4:0]  bit_cnt;
  logic [9:0]  res_x, x_out;
  logic [8:0]  res_y, y_out;
  logic [18:0] count_out;
  logic        found_out, valid_out;

  logic        boundary;
  logic        is_marker;
  logic [8:0]  r_lim, b_lim;
  logic [19:0] rem_sh;
  logic        take;
  logic [18:0] rem_nx;
  logic [27:0] quo_nx;

  assign boundary = vs_d2 & ~vs_d1;

  // Margins are added in 9 bits so a bright red/blue can never wrap into a pass.
  assign r_lim     = {1'b0, bus.iRed}  + {1'b0, G_MARGIN};
  assign b_lim     = {1'b0, bus.iBlue} + {1'b0, G_MARGIN};
  assign is_marker = bus.iDE && (bus.iGreen >= G_MIN) &&
                     ({1'b0, bus.iGreen} >= r_lim) && ({1'b0, bus.iGreen} >= b_lim);

  // One restoring-division step: remainder stays below the 19-bit divisor.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rem_sh = {rem, quo[27]};
    take   = rem_sh >= {1'b0, op_cnt};
    rem_nx = rem_sh[18:0];
    if (take) rem_nx = 19'(rem_sh - {1'b0, op_cnt});
    quo_nx = {quo[26:0], take};
  end

  function automatic logic [9:0] clamp_x(input logic [27:0] q);
    return (q > 28'(H_ACTIVE - 1)) ? 10'(H_ACTIVE - 1) : q[9:0];
  endfunction

  function automatic logic [8:0] clamp_y(input logic [27:0] q);
    return (q > 28'(V_ACTIVE - 1)) ? 9'(V_ACTIVE - 1) : q[8:0];
  endfunction

  // Pixel pipeline: position counters, classification stage, accumulators.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the pre-edge values.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      x_cnt  <= '0;
      y_cnt  <= '0;
      vs_d1  <= 1'b0;
      vs_d2  <= 1'b0;
      mark_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      sum_x  <= '0;
      sum_y  <= '0;
      cnt    <= '0;
    end else begin
      vs_d1  <= bus.iVS;
      vs_d2  <= vs_d1;
      mark_q <= is_marker;
      x_q    <= x_cnt;
      y_q    <= y_cnt;
      if (boundary) begin
        x_cnt <= '0;
        y_cnt <= '0;
        // A pixel leaving stage 2 on this edge opens the new frame.
        sum_x <= mark_q ? 28'(x_q) : '0;
        sum_y <= mark_q ? 28'(y_q) : '0;
        cnt   <= mark_q ? 19'd1 : '0;
      end else begin
        if (bus.iDE) begin
          if (x_cnt == 10'(H_ACTIVE - 1)) begin
            x_cnt <= '0;
            if (y_cnt != 9'(V_ACTIVE - 1)) y_cnt <= y_cnt + 9'd1;
          end else begin
            x_cnt <= x_cnt + 10'd1;
          end
        end
        if (mark_q) begin
          sum_x <= sum_x + 28'(x_q);
          sum_y <= sum_y + 28'(y_q);
          if (cnt != '1) cnt <= cnt + 19'd1;
        end
      end
    end
  end

  // Frame controller: snapshot at the boundary, two 28-step divides, publish.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= ACCUM;
      quo       <= '0;
      rem       <= '0;
      op_y      <= '0;
      op_cnt    <= '0;
      bit_cnt   <= '0;
      res_x     <= '0;
      res_y     <= '0;
      x_out     <= 10'(H_ACTIVE / 2);
      y_out     <= 9'(V_ACTIVE / 2);
      count_out <= '0;
      found_out <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        ACCUM: begin
          if (boundary) begin
            quo     <= sum_x;
            op_y    <= sum_y;
            op_cnt  <= cnt;
            rem     <= '0;
            bit_cnt <= '0;
            state   <= (cnt >= 19'(MIN_COUNT)) ? DIV_X : PUBLISH;
          end
        end
        DIV_X: begin
          quo     <= quo_nx;
          rem     <= rem_nx;
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd27) begin
            res_x   <= clamp_x(quo_nx);
            quo     <= op_y;
            rem     <= '0;
            bit_cnt <= '0;
            state   <= DIV_Y;
          end
        end
        DIV_Y: begin
          quo     <= quo_nx;
          rem     <= rem_nx;
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd27) begin
            res_y <= clamp_y(quo_nx);
            state <= PUBLISH;
          end
        end
        PUBLISH: begin
          valid_out <= 1'b1;
          count_out <= op_cnt;
          found_out <= op_cnt >= 19'(MIN_COUNT);
          if (op_cnt >= 19'(MIN_COUNT)) begin
            x_out <= res_x;
            y_out <= res_y;
          end
          state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.oX     = x_out;
  assign bus.oY     = y_out;
  assign bus.oCount = count_out;
  assign bus.oFound = found_out;
  assign bus.oValid = valid_out;

endmodule
